// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC generation, imem request/busywait handshake, one-entry fetch buffer.
// Define IFU_ALIGN_FORCE_EN to force branch targets to word alignment.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC,
  output logic        OUT_BUSYWAIT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] target_q, target_d;
  logic [31:0] tgt;
  logic        rd;
  logic        done;

`ifdef IFU_ALIGN_FORCE_EN
  assign tgt = {BRANCH_TARGET[31:2], 2'b00};
`else
  assign tgt = BRANCH_TARGET;
`endif

  assign IMEM_READ       = rd;
  assign IMEM_ADDRESS    = fetch_pc_q;
  assign OUT_INSTRUCTION = buf_instr_q;
  assign OUT_PC          = buf_pc_q;
  assign OUT_BUSYWAIT    = ~buf_valid_q | STALL;
  assign done            = rd & ~IMEM_BUSYWAIT;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    target_d    = target_q;
    rd          = 1'b0;

    if (buf_valid_q && !STALL)
      buf_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        if (BRANCH_TAKEN)
          fetch_pc_d = tgt;
      end
      S_RUN: begin
        rd = ~buf_valid_q | ~STALL;
        if (BRANCH_TAKEN) begin
          // a busy request must finish at the old address before redirecting
          if (rd && IMEM_BUSYWAIT) begin
            target_d = tgt;
            state_d  = S_DRAIN;
          end else begin
            fetch_pc_d = tgt;
          end
        end else if (done) begin
          buf_instr_d = IMEM_READDATA;
          buf_pc_d    = fetch_pc_q;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + 32'd4;
        end else if (rd) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rd = 1'b1;
        if (BRANCH_TAKEN) begin
          if (IMEM_BUSYWAIT) begin
            target_d = tgt;
            state_d  = S_DRAIN;
          end else begin
            fetch_pc_d = tgt;
            state_d    = S_RUN;
          end
        end else if (done) begin
          buf_instr_d = IMEM_READDATA;
          buf_pc_d    = fetch_pc_q;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + 32'd4;
          state_d     = S_RUN;
        end
      end
      S_DRAIN: begin
        rd = 1'b1;
        if (done) begin
          fetch_pc_d = BRANCH_TAKEN ? tgt : target_q;
          state_d    = S_RUN;
        end else if (BRANCH_TAKEN) begin
          target_d = tgt;
        end
      end
    endcase

    if (BRANCH_TAKEN)
      buf_valid_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      buf_valid_q <= 1'b0;
      target_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      target_q    <= target_d;
    end
  end

endmodule
